// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM state encoding
//   NOP_INSTR     : word the instruction memory returns after a flush
//   PC_INC        : byte increment between sequential instructions
//   align_word()  : clears the two byte-offset bits of an address
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    DRAIN = 3'd3,
    REDIR = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// ---------------------------------------------------------------------------
// fetch_next_pc
// Combinational next-PC select and redirect misalignment detect.
// Ports:
//   pc         in  32  current fetch PC
//   issue      in  1   a read of pc is issued this cycle
//   br_taken   in  1   redirect request
//   br_target  in  32  redirect byte address
//   pc_next    out 32  PC for the next cycle (hold / +4 / aligned target)
//   misalign   out 1   redirect target has nonzero byte offset
// ---------------------------------------------------------------------------
module fetch_next_pc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        issue,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc_next,
  output logic        misalign
);

  always_comb begin
    pc_next = pc;
    if (br_taken) begin
      pc_next = align_word(br_target);
    end else if (issue) begin
      pc_next = pc + PC_INC;  // wraps modulo 2^32
    end
  end

  assign misalign = br_taken & (br_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Requester side of a 1-cycle registered instruction memory. Owns the PC,
// issues reads, pairs each returned word with its PC, handles decode stalls,
// redirects and fetch enable, and keeps saturating fetch/stall counters.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | no issue; waits for fetch_en
//   RUN   | issues one read per cycle unless the live word is stalled
//   STALL | live word held in memory output; no issue until decode accepts
//   DRAIN | fetch disabled; last in-flight word delivered, then IDLE
//   REDIR | one flush cycle after a redirect; target issued next cycle
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fetch_en            permit instruction issue
//   id_stall            decode cannot accept if_instr this cycle
//   br_taken/br_target  redirect pulse and byte target
//   imem_pc/read_en/flush/instr   instruction memory interface
//   if_instr/if_pc/if_valid       instruction to decode
//   misalign_err        1-cycle pulse on misaligned redirect target
//   fetch_cnt/stall_cnt saturating performance counters
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic             id_stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic [31:0]      imem_pc,
  output logic             imem_read_en,
  output logic             imem_flush,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic             if_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic             resp_valid_q, resp_valid_d;
  logic             misalign_q;
  logic             misalign_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic resp_stall;
  logic consumed;
  logic issue;

  assign resp_stall = resp_valid_q & id_stall;
  assign consumed   = resp_valid_q & ~id_stall;

  // Issue is suppressed while the live word is stalled so the memory keeps
  // holding it; a stall against a bubble does not block issue.
  assign issue = (state_q == RUN) & fetch_en & ~resp_stall & ~br_taken & ~rst;

  fetch_next_pc u_next_pc (
    .pc        (pc_q),
    .issue     (issue),
    .br_taken  (br_taken),
    .br_target (br_target),
    .pc_next   (pc_d),
    .misalign  (misalign_d)
  );

  always_comb begin
    state_d = state_q;
    if (br_taken) begin
      state_d = REDIR;
    end else begin
      case (state_q)
        IDLE:    if (fetch_en) state_d = RUN;
        RUN: begin
          if (resp_stall)     state_d = STALL;
          else if (!fetch_en) state_d = DRAIN;
        end
        STALL:   if (!id_stall) state_d = RUN;
        DRAIN: begin
          if (fetch_en)         state_d = RUN;
          else if (!resp_stall) state_d = IDLE;
        end
        REDIR:   state_d = fetch_en ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_pc_d    = resp_pc_q;
    if (br_taken) begin
      // A redirect kills whatever word is live, including one held by a stall.
      resp_valid_d = 1'b0;
    end else if (issue) begin
      resp_valid_d = 1'b1;
      resp_pc_d    = pc_q;
    end else if (consumed) begin
      resp_valid_d = 1'b0;
    end
  end

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (consumed && fetch_cnt_q != CNT_MAX) fetch_cnt_d = fetch_cnt_q + CNT_ONE;
    if (resp_stall && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      resp_pc_q    <= 32'h0;
      resp_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      fetch_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      misalign_q   <= misalign_d;
      fetch_cnt_q  <= fetch_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign imem_pc      = pc_q;
  assign imem_read_en = issue;
  assign imem_flush   = (state_q == REDIR) & ~rst;
  assign if_instr     = imem_instr;
  assign if_pc        = resp_pc_q;
  assign if_valid     = resp_valid_q;
  assign misalign_err = misalign_q;
  assign fetch_cnt    = fetch_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule
